// File: rtl/sweep_pulse_pkg.sv
// Shared constants for the sweep pulse channel: default widths, sweep FSM
// encoding and duty waveform tables (leftmost character is step 0).
package sweep_pulse_pkg;

  localparam int DEF_FREQ_W    = 11;
  localparam int DEF_LEN_W     = 6;
  localparam int DEF_VOL_W     = 4;
  localparam int DEF_EPER_W    = 3;
  localparam int DEF_SPER_W    = 3;
  localparam int DEF_SHIFT_W   = 3;
  localparam int DEF_TIMER_DIV = 4;

  localparam logic [1:0] SWP_IDLE    = 2'd0;
  localparam logic [1:0] SWP_CALC    = 2'd1;
  localparam logic [1:0] SWP_RECHECK = 2'd2;
  localparam logic [1:0] SWP_CHECK   = 2'd3;

  localparam logic [7:0] DUTY_12 = 8'b0000_0001;
  localparam logic [7:0] DUTY_25 = 8'b1000_0001;
  localparam logic [7:0] DUTY_50 = 8'b1000_0111;
  localparam logic [7:0] DUTY_75 = 8'b0111_1110;

  function automatic logic duty_bit(input logic [1:0] duty, input logic [2:0] step);
    logic [7:0] pat;
    case (duty)
      2'b00:   pat = DUTY_12;
      2'b01:   pat = DUTY_25;
      2'b10:   pat = DUTY_50;
      2'b11:   pat = DUTY_75;
      default: pat = DUTY_12;
    endcase
    return pat[3'd7 - step];
  endfunction

endpackage

// File: rtl/sweep_unit.sv
// Frequency sweep: sweep divider, IDLE/CALC/RECHECK/CHECK sequencer and the
// shadow-frequency adder with overflow detection.
module sweep_unit
  import sweep_pulse_pkg::*;
#(
  parameter int FREQ_W  = DEF_FREQ_W,
  parameter int SPER_W  = DEF_SPER_W,
  parameter int SHIFT_W = DEF_SHIFT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trigger,
  input  logic              tick_128,
  input  logic [FREQ_W-1:0] freq,
  input  logic [SPER_W-1:0] sweep_period,
  input  logic              sweep_negate,
  input  logic [SHIFT_W-1:0] sweep_shift,
  output logic [FREQ_W-1:0] shadow,
  output logic              sweep_dis
);

  localparam logic [SPER_W:0] SCTR_FULL = {1'b1, {SPER_W{1'b0}}};
  localparam logic [SPER_W:0] SCTR_ONE  = {{SPER_W{1'b0}}, 1'b1};

  logic [1:0]        state_r, state_n_s;
  logic [FREQ_W-1:0] shadow_r, shadow_n_s, delta_s;
  logic [SPER_W:0]   sctr_r, sctr_n_s, sctr_reload_s;
  logic              sweep_on_r;
  logic [FREQ_W:0]   sum_s;
  logic              period_zero_s, shift_zero_s, ovf_s;

  // Adder is one bit wider than shadow so bit FREQ_W flags overflow.
  always_comb begin
    delta_s       = shadow_r >> sweep_shift;
    period_zero_s = (sweep_period == {SPER_W{1'b0}});
    shift_zero_s  = (sweep_shift == {SHIFT_W{1'b0}});
    sctr_reload_s = period_zero_s ? SCTR_FULL : {1'b0, sweep_period};
    if (sweep_negate) begin
      sum_s = {1'b0, shadow_r} - {1'b0, delta_s};
    end else begin
      sum_s = {1'b0, shadow_r} + {1'b0, delta_s};
    end
    ovf_s     = sum_s[FREQ_W];
    sweep_dis = (state_r != SWP_IDLE) && ovf_s;
  end

  // Sequencer next-state and divider logic.
  always_comb begin
    state_n_s  = state_r;
    shadow_n_s = shadow_r;
    sctr_n_s   = sctr_r;
    case (state_r)
      SWP_IDLE: begin
        if (tick_128) begin
          if (sctr_r <= SCTR_ONE) begin
            sctr_n_s = sctr_reload_s;
            if (sweep_on_r && !period_zero_s) begin
              state_n_s = SWP_CALC;
            end else begin
              state_n_s = SWP_IDLE;
            end
          end else begin
            sctr_n_s = sctr_r - SCTR_ONE;
          end
        end else begin
          sctr_n_s = sctr_r;
        end
      end
      SWP_CALC: begin
        if (ovf_s) begin
          state_n_s = SWP_IDLE;
        end else if (!shift_zero_s) begin
          shadow_n_s = sum_s[FREQ_W-1:0];
          state_n_s  = SWP_RECHECK;
        end else begin
          state_n_s = SWP_IDLE;
        end
      end
      SWP_RECHECK: state_n_s = SWP_IDLE;
      SWP_CHECK:   state_n_s = SWP_IDLE;
      default:     state_n_s = SWP_IDLE;
    endcase
  end

  // Sweep state registers; a trigger restarts the sweep from freq.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= SWP_IDLE;
      shadow_r   <= {FREQ_W{1'b0}};
      sctr_r     <= {(SPER_W+1){1'b0}};
      sweep_on_r <= 1'b0;
    end else if (trigger) begin
      state_r    <= shift_zero_s ? SWP_IDLE : SWP_CHECK;
      shadow_r   <= freq;
      sctr_r     <= sctr_reload_s;
      sweep_on_r <= !period_zero_s || !shift_zero_s;
    end else begin
      state_r    <= state_n_s;
      shadow_r   <= shadow_n_s;
      sctr_r     <= sctr_n_s;
      sweep_on_r <= sweep_on_r;
    end
  end

  assign shadow = shadow_r;

endmodule

// File: rtl/sweep_pulse_channel.sv
// Square-wave channel with duty generator, length counter, volume envelope
// and optional frequency sweep; frame ticks arrive as one-cycle enables.
module sweep_pulse_channel
  import sweep_pulse_pkg::*;
#(
  parameter int FREQ_W    = DEF_FREQ_W,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int VOL_W     = DEF_VOL_W,
  parameter int EPER_W    = DEF_EPER_W,
  parameter int SPER_W    = DEF_SPER_W,
  parameter int SHIFT_W   = DEF_SHIFT_W,
  parameter int TIMER_DIV = DEF_TIMER_DIV,
  parameter int SWEEP_EN  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_256,
  input  logic               tick_128,
  input  logic               tick_64,
  input  logic               trigger,
  input  logic [FREQ_W-1:0]  freq,
  input  logic [SPER_W-1:0]  sweep_period,
  input  logic               sweep_negate,
  input  logic [SHIFT_W-1:0] sweep_shift,
  input  logic [LEN_W-1:0]   length_load,
  input  logic               length_enable,
  input  logic [1:0]         duty_cycle,
  input  logic [VOL_W-1:0]   starting_volume,
  input  logic [EPER_W-1:0]  env_period,
  input  logic               env_add,
  output logic [VOL_W-1:0]   amplitude,
  output logic               enabled,
  output logic [FREQ_W-1:0]  freq_out
);

  localparam int TMR_W = FREQ_W + $clog2(TIMER_DIV);
  localparam logic [LEN_W:0]    LEN_FULL = {1'b1, {LEN_W{1'b0}}};
  localparam logic [LEN_W:0]    LEN_ONE  = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [VOL_W-1:0]  VOL_MAX  = {VOL_W{1'b1}};
  localparam logic [VOL_W-1:0]  VOL_ONE  = {{(VOL_W-1){1'b0}}, 1'b1};
  localparam logic [EPER_W-1:0] EPER_ONE = {{(EPER_W-1){1'b0}}, 1'b1};
  localparam logic [TMR_W-1:0]  TMR_ONE  = {{(TMR_W-1){1'b0}}, 1'b1};

  logic [FREQ_W-1:0] shadow_s, tmr_src_s;
  logic              sweep_dis_s;
  logic [TMR_W-1:0]  tmr_r, tmr_reload_s;
  logic [2:0]        step_r;
  logic [LEN_W:0]    len_ctr_r;
  logic [EPER_W-1:0] env_ctr_r;
  logic [VOL_W-1:0]  volume_r, amp_r;
  logic              enabled_r;

  generate
    if (SWEEP_EN != 0) begin : g_sweep
      sweep_unit #(
        .FREQ_W (FREQ_W),
        .SPER_W (SPER_W),
        .SHIFT_W(SHIFT_W)
      ) u_sweep (
        .clk         (clk),
        .reset       (reset),
        .trigger     (trigger),
        .tick_128    (tick_128),
        .freq        (freq),
        .sweep_period(sweep_period),
        .sweep_negate(sweep_negate),
        .sweep_shift (sweep_shift),
        .shadow      (shadow_s),
        .sweep_dis   (sweep_dis_s)
      );
    end else begin : g_nosweep
      logic [FREQ_W-1:0] shadow_r;
      logic              sweep_unused_s;
      assign sweep_unused_s = ^{tick_128, sweep_period, sweep_negate, sweep_shift};
      // Without sweep hardware the shadow simply follows freq.
      always_ff @(posedge clk) begin
        if (reset) begin
          shadow_r <= {FREQ_W{1'b0}};
        end else begin
          shadow_r <= freq;
        end
      end
      assign shadow_s    = shadow_r;
      assign sweep_dis_s = 1'b0;
    end
  endgenerate

  // (2^F - f)*D - 1 rewritten as ~f*D + (D-1) so it fits TMR_W exactly.
  always_comb begin
    tmr_src_s    = trigger ? freq : shadow_s;
    tmr_reload_s = TMR_W'(~tmr_src_s) * TMR_W'(TIMER_DIV) + TMR_W'(TIMER_DIV - 1);
  end

  // Frequency timer and duty step; free-running regardless of enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmr_r  <= {TMR_W{1'b0}};
      step_r <= 3'd0;
    end else if (trigger) begin
      tmr_r  <= tmr_reload_s;
      step_r <= 3'd0;
    end else if (tmr_r == {TMR_W{1'b0}}) begin
      tmr_r  <= tmr_reload_s;
      step_r <= step_r + 3'd1;
    end else begin
      tmr_r  <= tmr_r - TMR_ONE;
    end
  end

  // Channel enable and length counter; sweep overflow also disables.
  always_ff @(posedge clk) begin
    if (reset) begin
      enabled_r <= 1'b0;
      len_ctr_r <= {(LEN_W+1){1'b0}};
    end else if (trigger) begin
      enabled_r <= 1'b1;
      len_ctr_r <= LEN_FULL - {1'b0, length_load};
    end else begin
      if (tick_256 && length_enable && (len_ctr_r != {(LEN_W+1){1'b0}})) begin
        len_ctr_r <= len_ctr_r - LEN_ONE;
        if (len_ctr_r == LEN_ONE) begin
          enabled_r <= 1'b0;
        end
      end
      if (sweep_dis_s) begin
        enabled_r <= 1'b0;
      end
    end
  end

  // Volume envelope with saturating steps.
  always_ff @(posedge clk) begin
    if (reset) begin
      volume_r  <= {VOL_W{1'b0}};
      env_ctr_r <= {EPER_W{1'b0}};
    end else if (trigger) begin
      volume_r  <= starting_volume;
      env_ctr_r <= env_period;
    end else if (tick_64 && (env_period != {EPER_W{1'b0}})) begin
      if (env_ctr_r <= EPER_ONE) begin
        env_ctr_r <= env_period;
        if (env_add) begin
          if (volume_r != VOL_MAX) begin
            volume_r <= volume_r + VOL_ONE;
          end
        end else if (volume_r != {VOL_W{1'b0}}) begin
          volume_r <= volume_r - VOL_ONE;
        end
      end else begin
        env_ctr_r <= env_ctr_r - EPER_ONE;
      end
    end
  end

  // Registered output sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      amp_r <= {VOL_W{1'b0}};
    end else if (enabled_r && duty_bit(duty_cycle, step_r)) begin
      amp_r <= volume_r;
    end else begin
      amp_r <= {VOL_W{1'b0}};
    end
  end

  assign amplitude = amp_r;
  assign enabled   = enabled_r;
  assign freq_out  = shadow_s;

endmodule

// File: tb/tb_sweep_pulse_channel.sv
// Directed bench for sweep_pulse_channel: sweep build plus a sweep-less build.
module tb_sweep_pulse_channel;

  logic        clk = 1'b0;
  logic        reset, tick_256, tick_128, tick_64, trigger;
  logic [10:0] freq;
  logic [2:0]  sweep_period, sweep_shift, env_period;
  logic        sweep_negate, length_enable, env_add;
  logic [5:0]  length_load;
  logic [1:0]  duty_cycle;
  logic [3:0]  starting_volume;
  logic [3:0]  amplitude, amp_ns;
  logic        enabled, en_ns;
  logic [10:0] freq_out, fo_ns;

  int checks = 0;
  int errors = 0;
  logic [7:0] duty_exp;

  always #5 clk = ~clk;

  sweep_pulse_channel #(.SWEEP_EN(1)) u_dut (
    .clk(clk), .reset(reset), .tick_256(tick_256), .tick_128(tick_128),
    .tick_64(tick_64), .trigger(trigger), .freq(freq),
    .sweep_period(sweep_period), .sweep_negate(sweep_negate),
    .sweep_shift(sweep_shift), .length_load(length_load),
    .length_enable(length_enable), .duty_cycle(duty_cycle),
    .starting_volume(starting_volume), .env_period(env_period),
    .env_add(env_add), .amplitude(amplitude), .enabled(enabled),
    .freq_out(freq_out)
  );

  sweep_pulse_channel #(.SWEEP_EN(0)) u_dut_ns (
    .clk(clk), .reset(reset), .tick_256(tick_256), .tick_128(tick_128),
    .tick_64(tick_64), .trigger(trigger), .freq(freq),
    .sweep_period(sweep_period), .sweep_negate(sweep_negate),
    .sweep_shift(sweep_shift), .length_load(length_load),
    .length_enable(length_enable), .duty_cycle(duty_cycle),
    .starting_volume(starting_volume), .env_period(env_period),
    .env_add(env_add), .amplitude(amp_ns), .enabled(en_ns),
    .freq_out(fo_ns)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    cyc(1);
    trigger = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick_256 = 1'b0; tick_128 = 1'b0; tick_64 = 1'b0; trigger = 1'b0;
    freq = 11'd0; sweep_period = 3'd0; sweep_shift = 3'd0; sweep_negate = 1'b0;
    length_load = 6'd0; length_enable = 1'b0; duty_cycle = 2'b00;
    starting_volume = 4'd0; env_period = 3'd0; env_add = 1'b0;
    cyc(3);
    chk("reset_amp", 32'(amplitude), 32'd0);
    chk("reset_en", 32'(enabled), 32'd0);
    chk("reset_fout", 32'(freq_out), 32'd0);
    chk("reset_fout_ns", 32'(fo_ns), 32'd0);
    reset = 1'b0;

    // Duty 50% pattern, 1024 clocks per step
    freq = 11'd1792; duty_cycle = 2'b10; starting_volume = 4'd15;
    duty_exp = 8'b1000_0111;
    pulse_trigger();
    chk("duty_en", 32'(enabled), 32'd1);
    chk("duty_fout", 32'(freq_out), 32'd1792);
    cyc(512);
    chk("duty_step0", 32'(amplitude), 32'd15);
    for (int s = 1; s < 8; s++) begin
      cyc(1024);
      chk($sformatf("duty_step%0d", s), 32'(amplitude), duty_exp[7-s] ? 32'd15 : 32'd0);
    end

    // Length counter: 64-60 = 4 ticks
    length_load = 6'd60; length_enable = 1'b1;
    pulse_trigger();
    for (int i = 1; i <= 4; i++) begin
      tick_256 = 1'b1;
      cyc(1);
      tick_256 = 1'b0;
      chk($sformatf("len_tick%0d", i), 32'(enabled), (i < 4) ? 32'd1 : 32'd0);
    end
    chk("len_amp_lag", 32'(amplitude), 32'd15);
    cyc(1);
    chk("len_amp_off", 32'(amplitude), 32'd0);

    // Envelope decay with saturation at 0
    length_enable = 1'b0; starting_volume = 4'd2; env_add = 1'b0; env_period = 3'd1;
    pulse_trigger();
    cyc(1);
    chk("env_start", 32'(amplitude), 32'd2);
    for (int i = 0; i < 3; i++) begin
      tick_64 = 1'b1;
      cyc(1);
      tick_64 = 1'b0;
      cyc(1);
      chk($sformatf("env_tick%0d", i), 32'(amplitude), (i == 0) ? 32'd1 : 32'd0);
    end
    env_period = 3'd0; starting_volume = 4'd15;

    // Sweep up: 1024 -> 1536, recheck 2304 overflows
    freq = 11'd1024; sweep_shift = 3'd1; sweep_negate = 1'b0; sweep_period = 3'd1;
    pulse_trigger();
    cyc(2);
    chk("swp_check_en", 32'(enabled), 32'd1);
    chk("swp_check_fout", 32'(freq_out), 32'd1024);
    tick_128 = 1'b1;
    cyc(1);
    tick_128 = 1'b0;
    cyc(1);
    chk("swp_calc_fout", 32'(freq_out), 32'd1536);
    chk("swp_calc_en", 32'(enabled), 32'd1);
    cyc(1);
    chk("swp_recheck_en", 32'(enabled), 32'd0);

    // Post-trigger check overflows immediately: 1500 + 750
    freq = 11'd1500;
    pulse_trigger();
    chk("chk_ovf_en0", 32'(enabled), 32'd1);
    cyc(1);
    chk("chk_ovf_en1", 32'(enabled), 32'd0);
    chk("chk_ovf_fout", 32'(freq_out), 32'd1500);

    // Negate sweep: 1024 - 256 = 768, recheck 576 is fine
    freq = 11'd1024; sweep_shift = 3'd2; sweep_negate = 1'b1;
    pulse_trigger();
    cyc(2);
    tick_128 = 1'b1;
    cyc(1);
    tick_128 = 1'b0;
    cyc(2);
    chk("neg_fout", 32'(freq_out), 32'd768);
    chk("neg_en", 32'(enabled), 32'd1);

    // Reset while the sweep FSM sits in CALC
    freq = 11'd512; sweep_shift = 3'd1; sweep_negate = 1'b0;
    pulse_trigger();
    cyc(2);
    tick_128 = 1'b1;
    cyc(1);
    tick_128 = 1'b0;
    reset = 1'b1;
    cyc(1);
    chk("rst_calc_amp", 32'(amplitude), 32'd0);
    chk("rst_calc_en", 32'(enabled), 32'd0);
    chk("rst_calc_fout", 32'(freq_out), 32'd0);
    reset = 1'b0;
    cyc(3);
    chk("rst_idle_fout", 32'(freq_out), 32'd0);
    chk("rst_idle_en", 32'(enabled), 32'd0);

    // Trigger beats tick_256 in the same cycle
    freq = 11'd1792; sweep_shift = 3'd0; sweep_period = 3'd0;
    length_load = 6'd63; length_enable = 1'b1;
    trigger = 1'b1; tick_256 = 1'b1;
    cyc(1);
    trigger = 1'b0; tick_256 = 1'b0;
    chk("trig_tick_en", 32'(enabled), 32'd1);
    tick_256 = 1'b1;
    cyc(1);
    tick_256 = 1'b0;
    chk("trig_tick_next", 32'(enabled), 32'd0);

    // Sweep-less build tracks freq one cycle later
    freq = 11'd300;
    chk("ns_before", 32'(fo_ns), 32'd1792);
    cyc(1);
    chk("ns_after", 32'(fo_ns), 32'd300);
    chk("sweep_hold", 32'(freq_out), 32'd1792);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
